// File: rtl/sync_fifo_pro.sv
// Single-clock FIFO with arbitrary depth, programmable almost-full/empty thresholds,
// registered status pulses, flush, and selectable standard or first-word-fall-through read.
module sync_fifo_pro #(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int FWFT       = 0,
    localparam int AW = (FIFO_DEPTH <= 2) ? 1 : $clog2(FIFO_DEPTH),
    localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic                  flush,
    input  logic [CW-1:0]         af_thresh,
    input  logic [CW-1:0]         ae_thresh,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CW-1:0]         count
);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_ack_q, overflow_q, underflow_q;
    logic          rd_acc, wr_acc;

    assign full        = (count_q == CW'(FIFO_DEPTH));
    assign empty       = (count_q == '0);
    assign almostfull  = (count_q >= af_thresh);
    assign almostempty = (count_q <= ae_thresh);
    assign count       = count_q;
    assign wr_ack      = wr_ack_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

    // A read frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
    always_comb begin
        rd_acc   = rd_en && !empty && !flush;
        wr_acc   = wr_en && !flush && (!full || rd_acc);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_ack_q    <= wr_acc;
            overflow_q  <= wr_en && !wr_acc && !flush;
            underflow_q <= rd_en && empty && !flush;
        end
    end

    // Storage carries no reset so it maps onto RAM primitives.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    generate
        if (FWFT == 0) begin : g_std
            logic [FIFO_WIDTH-1:0] dout_q;
            logic                  valid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_acc;
                    if (rd_acc) begin
                        dout_q <= mem[rd_ptr_q];
                    end
                end
            end

            assign data_out = dout_q;
            assign valid    = valid_q;
        end else begin : g_fwft
            // Head word is always presented; a pop simply advances the read pointer.
            assign data_out = mem[rd_ptr_q];
            assign valid    = !empty;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_pro.sv
// Bench for sync_fifo_pro: a 16-deep standard-read instance and a 5-deep FWFT instance,
// each checked against a scoreboard queue and occupancy model every cycle.
module tb_sync_fifo_pro;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [7:0] a_din, a_dout;
    logic       a_wr, a_rd, a_fl;
    logic [4:0] a_af, a_ae, a_cnt;
    logic       a_valid, a_ack, a_ovf, a_unf, a_full, a_empty, a_afull, a_aempty;

    logic [7:0] b_din, b_dout;
    logic       b_wr, b_rd, b_fl;
    logic [2:0] b_af, b_ae, b_cnt;
    logic       b_valid, b_ack, b_ovf, b_unf, b_full, b_empty, b_afull, b_aempty;

    sync_fifo_pro #(.FIFO_WIDTH(8), .FIFO_DEPTH(16), .FWFT(0)) u_a (
        .clk(clk), .rst_n(rst_n), .data_in(a_din), .wr_en(a_wr), .rd_en(a_rd), .flush(a_fl),
        .af_thresh(a_af), .ae_thresh(a_ae), .data_out(a_dout), .valid(a_valid),
        .wr_ack(a_ack), .overflow(a_ovf), .underflow(a_unf), .full(a_full), .empty(a_empty),
        .almostfull(a_afull), .almostempty(a_aempty), .count(a_cnt)
    );

    sync_fifo_pro #(.FIFO_WIDTH(8), .FIFO_DEPTH(5), .FWFT(1)) u_b (
        .clk(clk), .rst_n(rst_n), .data_in(b_din), .wr_en(b_wr), .rd_en(b_rd), .flush(b_fl),
        .af_thresh(b_af), .ae_thresh(b_ae), .data_out(b_dout), .valid(b_valid),
        .wr_ack(b_ack), .overflow(b_ovf), .underflow(b_unf), .full(b_full), .empty(b_empty),
        .almostfull(b_afull), .almostempty(b_aempty), .count(b_cnt)
    );

    int total = 0;
    int bad   = 0;
    int a_mcnt = 0;
    int b_mcnt = 0;
    logic [7:0] a_q[$];
    logic [7:0] b_q[$];

    typedef struct {
        bit         wr;
        bit         rd;
        logic [7:0] din;
        int         cnt;
        bit         full;
        bit         ovf;
        bit         unf;
        bit         valid;
        logic [7:0] dout;
    } vec_t;

    vec_t vt[34];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic a_cycle(input logic wr, input logic rd, input logic fl, input logic [7:0] din);
        bit         rda, wra;
        int         pre;
        logic [7:0] ed;
        ed  = 8'h00;
        pre = a_mcnt;
        rda = rd && (pre > 0) && !fl;
        wra = wr && !fl && ((pre < 16) || rda);
        if (rda) ed = a_q.pop_front();
        if (wra) a_q.push_back(din);
        if (fl) begin
            a_q.delete();
            a_mcnt = 0;
        end else begin
            a_mcnt = pre + int'(wra) - int'(rda);
        end
        a_wr = wr; a_rd = rd; a_fl = fl; a_din = din;
        @(posedge clk);
        #1;
        a_wr = 1'b0; a_rd = 1'b0; a_fl = 1'b0;
        chk("A.count", 32'(a_cnt), 32'(a_mcnt));
        chk("A.full", 32'(a_full), 32'(a_mcnt == 16));
        chk("A.empty", 32'(a_empty), 32'(a_mcnt == 0));
        chk("A.almostfull", 32'(a_afull), 32'(a_mcnt >= int'(a_af)));
        chk("A.almostempty", 32'(a_aempty), 32'(a_mcnt <= int'(a_ae)));
        chk("A.wr_ack", 32'(a_ack), 32'(wra));
        chk("A.overflow", 32'(a_ovf), 32'(wr && !wra && !fl));
        chk("A.underflow", 32'(a_unf), 32'(rd && (pre == 0) && !fl));
        chk("A.valid", 32'(a_valid), 32'(rda));
        if (rda) chk("A.data_out", 32'(a_dout), 32'(ed));
        $display("A wr=%0d rd=%0d fl=%0d din=%02h -> count=%0d dout=%02h valid=%0d ack=%0d ovf=%0d unf=%0d",
                 wr, rd, fl, din, a_cnt, a_dout, a_valid, a_ack, a_ovf, a_unf);
    endtask

    task automatic b_cycle(input logic wr, input logic rd, input logic fl, input logic [7:0] din);
        bit rda, wra;
        int pre;
        pre = b_mcnt;
        rda = rd && (pre > 0) && !fl;
        wra = wr && !fl && ((pre < 5) || rda);
        if (rda) void'(b_q.pop_front());
        if (wra) b_q.push_back(din);
        if (fl) begin
            b_q.delete();
            b_mcnt = 0;
        end else begin
            b_mcnt = pre + int'(wra) - int'(rda);
        end
        b_wr = wr; b_rd = rd; b_fl = fl; b_din = din;
        @(posedge clk);
        #1;
        b_wr = 1'b0; b_rd = 1'b0; b_fl = 1'b0;
        chk("B.count", 32'(b_cnt), 32'(b_mcnt));
        chk("B.full", 32'(b_full), 32'(b_mcnt == 5));
        chk("B.empty", 32'(b_empty), 32'(b_mcnt == 0));
        chk("B.almostfull", 32'(b_afull), 32'(b_mcnt >= int'(b_af)));
        chk("B.almostempty", 32'(b_aempty), 32'(b_mcnt <= int'(b_ae)));
        chk("B.wr_ack", 32'(b_ack), 32'(wra));
        chk("B.overflow", 32'(b_ovf), 32'(wr && !wra && !fl));
        chk("B.underflow", 32'(b_unf), 32'(rd && (pre == 0) && !fl));
        chk("B.valid", 32'(b_valid), 32'(b_mcnt > 0));
        if (b_mcnt > 0) chk("B.data_out", 32'(b_dout), 32'(b_q[0]));
        $display("B wr=%0d rd=%0d fl=%0d din=%02h -> count=%0d dout=%02h valid=%0d ack=%0d ovf=%0d unf=%0d",
                 wr, rd, fl, din, b_cnt, b_dout, b_valid, b_ack, b_ovf, b_unf);
    endtask

    task automatic a_chk_reset(input string tag);
        chk({tag, ".count"}, 32'(a_cnt), 32'd0);
        chk({tag, ".empty"}, 32'(a_empty), 32'd1);
        chk({tag, ".full"}, 32'(a_full), 32'd0);
        chk({tag, ".valid"}, 32'(a_valid), 32'd0);
        chk({tag, ".wr_ack"}, 32'(a_ack), 32'd0);
        chk({tag, ".overflow"}, 32'(a_ovf), 32'd0);
        chk({tag, ".underflow"}, 32'(a_unf), 32'd0);
        chk({tag, ".data_out"}, 32'(a_dout), 32'd0);
        chk({tag, ".almostempty"}, 32'(a_aempty), 32'd1);
        chk({tag, ".almostfull"}, 32'(a_afull), 32'(a_af == 5'd0));
    endtask

    initial begin
        logic [7:0] hold;

        for (int i = 0; i < 16; i++) begin
            vt[i] = '{wr: 1'b1, rd: 1'b0, din: 8'(i + 1), cnt: i + 1, full: (i == 15),
                      ovf: 1'b0, unf: 1'b0, valid: 1'b0, dout: 8'h00};
        end
        vt[16] = '{wr: 1'b1, rd: 1'b0, din: 8'h11, cnt: 16, full: 1'b1,
                   ovf: 1'b1, unf: 1'b0, valid: 1'b0, dout: 8'h00};
        for (int i = 17; i < 33; i++) begin
            vt[i] = '{wr: 1'b0, rd: 1'b1, din: 8'h00, cnt: 32 - i, full: 1'b0,
                      ovf: 1'b0, unf: 1'b0, valid: 1'b1, dout: 8'(i - 16)};
        end
        vt[33] = '{wr: 1'b0, rd: 1'b1, din: 8'h00, cnt: 0, full: 1'b0,
                   ovf: 1'b0, unf: 1'b1, valid: 1'b0, dout: 8'h00};

        rst_n = 1'b0;
        a_din = 8'h00; a_wr = 1'b0; a_rd = 1'b0; a_fl = 1'b0; a_af = 5'd0; a_ae = 5'd2;
        b_din = 8'h00; b_wr = 1'b0; b_rd = 1'b0; b_fl = 1'b0; b_af = 3'd4; b_ae = 3'd1;
        repeat (2) @(posedge clk);
        #1;
        a_chk_reset("por");
        chk("por.B.empty", 32'(b_empty), 32'd1);
        chk("por.B.valid", 32'(b_valid), 32'd0);
        a_af = 5'd12;
        rst_n = 1'b1;

        // Fill to full, overflow once, drain in order, underflow once.
        for (int i = 0; i < 34; i++) begin
            a_cycle(vt[i].wr, vt[i].rd, 1'b0, vt[i].din);
            chk($sformatf("T%0d.count", i), 32'(a_cnt), 32'(vt[i].cnt));
            chk($sformatf("T%0d.full", i), 32'(a_full), 32'(vt[i].full));
            chk($sformatf("T%0d.overflow", i), 32'(a_ovf), 32'(vt[i].ovf));
            chk($sformatf("T%0d.underflow", i), 32'(a_unf), 32'(vt[i].unf));
            chk($sformatf("T%0d.valid", i), 32'(a_valid), 32'(vt[i].valid));
            if (vt[i].valid) chk($sformatf("T%0d.data_out", i), 32'(a_dout), 32'(vt[i].dout));
        end

        // Write and read together on an empty FIFO.
        a_cycle(1'b1, 1'b1, 1'b0, 8'h5A);
        chk("EWR.underflow", 32'(a_unf), 32'd1);
        chk("EWR.wr_ack", 32'(a_ack), 32'd1);
        chk("EWR.count", 32'(a_cnt), 32'd1);
        a_cycle(1'b0, 1'b1, 1'b0, 8'h00);

        // Full FIFO with simultaneous write/read; threshold crossings along the way.
        for (int i = 0; i < 16; i++) begin
            a_cycle(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
            if (a_mcnt == 11) chk("AF.at11", 32'(a_afull), 32'd0);
            if (a_mcnt == 12) chk("AF.at12", 32'(a_afull), 32'd1);
        end
        a_cycle(1'b1, 1'b1, 1'b0, 8'hAA);
        chk("FWR.overflow", 32'(a_ovf), 32'd0);
        chk("FWR.count", 32'(a_cnt), 32'd16);
        chk("FWR.wr_ack", 32'(a_ack), 32'd1);
        for (int i = 0; i < 16; i++) begin
            a_cycle(1'b0, 1'b1, 1'b0, 8'h00);
            if (a_mcnt == 3) chk("AE.at3", 32'(a_aempty), 32'd0);
            if (a_mcnt == 2) chk("AE.at2", 32'(a_aempty), 32'd1);
        end
        chk("FWR.last", 32'(a_dout), 32'hAA);

        // Flush beats a concurrent write; data_out holds.
        for (int i = 0; i < 7; i++) a_cycle(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        chk("FL.pre_count", 32'(a_cnt), 32'd7);
        hold = a_dout;
        a_cycle(1'b1, 1'b0, 1'b1, 8'h55);
        chk("FL.count", 32'(a_cnt), 32'd0);
        chk("FL.empty", 32'(a_empty), 32'd1);
        chk("FL.wr_ack", 32'(a_ack), 32'd0);
        chk("FL.data_out", 32'(a_dout), 32'(hold));
        a_cycle(1'b1, 1'b0, 1'b0, 8'h66);
        a_cycle(1'b0, 1'b1, 1'b0, 8'h00);

        // Asynchronous reset mid-burst, observed before any further edge.
        a_cycle(1'b1, 1'b0, 1'b0, 8'h01);
        a_cycle(1'b1, 1'b0, 1'b0, 8'h02);
        a_cycle(1'b1, 1'b1, 1'b0, 8'h03);
        rst_n = 1'b0;
        #1;
        a_chk_reset("arst");
        a_mcnt = 0;
        a_q.delete();
        b_mcnt = 0;
        b_q.delete();
        #2;
        rst_n = 1'b1;
        a_cycle(1'b1, 1'b0, 1'b0, 8'h77);
        a_cycle(1'b0, 1'b1, 1'b0, 8'h00);
        chk("ARST.first", 32'(a_dout), 32'h77);

        // FWFT: write/read on empty, then the word falls through.
        b_cycle(1'b1, 1'b1, 1'b0, 8'h3C);
        chk("BEWR.underflow", 32'(b_unf), 32'd1);
        chk("BEWR.wr_ack", 32'(b_ack), 32'd1);
        chk("BEWR.count", 32'(b_cnt), 32'd1);
        chk("BEWR.valid", 32'(b_valid), 32'd1);
        chk("BEWR.data_out", 32'(b_dout), 32'h3C);
        b_cycle(1'b0, 1'b1, 1'b0, 8'h00);

        // Depth 5: count oscillates 0..3 so the pointers wrap 4->0.
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < 3; k++) b_cycle(1'b1, 1'b0, 1'b0, 8'(g * 3 + k + 1));
            chk("WRAP.peak", 32'(b_cnt), 32'd3);
            for (int k = 0; k < 3; k++) b_cycle(1'b0, 1'b1, 1'b0, 8'h00);
            chk("WRAP.empty", 32'(b_empty), 32'd1);
        end

        // Depth 5 full and overflow.
        for (int i = 0; i < 6; i++) b_cycle(1'b1, 1'b0, 1'b0, 8'(8'h90 + i));
        chk("BOVF.overflow", 32'(b_ovf), 32'd1);
        chk("BOVF.count", 32'(b_cnt), 32'd5);
        for (int i = 0; i < 5; i++) b_cycle(1'b0, 1'b1, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo_pro.md
SYNC_FIFO_PRO -- requirements
Module: sync_fifo_pro

Interface
REQ-001 The block SHALL have parameter FIFO_WIDTH, default 8, meaning data word width in bits (>=1).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16, meaning the number of storage entries; any integer >=2, power of two not required.
REQ-003 The block SHALL have parameter FWFT, default 0, meaning read mode: 0 = standard registered read, 1 = first-word-fall-through.
REQ-004 The block SHALL derive localparam AW = max(1, $clog2(FIFO_DEPTH)) for pointer width and CW = $clog2(FIFO_DEPTH+1) for level width.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-007 The block SHALL have port data_in, input, FIFO_WIDTH, the write data.
REQ-008 The block SHALL have port wr_en, input, 1, the write request.
REQ-009 The block SHALL have port rd_en, input, 1, the read/pop request.
REQ-010 The block SHALL have port flush, input, 1, the synchronous empty command.
REQ-011 The block SHALL have port af_thresh, input, CW, the almost-full threshold.
REQ-012 The block SHALL have port ae_thresh, input, CW, the almost-empty threshold.
REQ-013 The block SHALL have port data_out, output, FIFO_WIDTH, the read data.
REQ-014 The block SHALL have port valid, output, 1, qualifying data_out.
REQ-015 The block SHALL have ports wr_ack, overflow and underflow, each output, 1, as registered status pulses.
REQ-016 The block SHALL have ports full, empty, almostfull and almostempty, each output, 1, as level flags.
REQ-017 The block SHALL have port count, output, CW, the current occupancy.

Function
REQ-018 rd_acc SHALL equal rd_en && !empty && !flush.
REQ-019 wr_acc SHALL equal wr_en && !flush && (!full || rd_acc); a write into a full FIFO SHALL be accepted when a read pops in the same cycle.
REQ-020 An accepted write SHALL store data_in at mem[wr_ptr], and wr_ptr SHALL advance, wrapping from FIFO_DEPTH-1 to 0.
REQ-021 An accepted read SHALL advance rd_ptr with the same wrap rule.
REQ-022 count SHALL update each cycle to count + wr_acc - rd_acc, with no other arithmetic path; it SHALL never exceed FIFO_DEPTH and never go below 0.
REQ-023 Simultaneous write and read on an empty FIFO: the write SHALL be accepted, the read rejected with underflow, and count SHALL become 1.
REQ-024 Flags SHALL be combinational from registered count: full = (count==FIFO_DEPTH); empty = (count==0); almostfull = (count>=af_thresh); almostempty = (count<=ae_thresh).
REQ-025 wr_ack SHALL be 1 exactly in the cycle after an accepted write, otherwise 0.
REQ-026 overflow SHALL be 1 in the cycle after wr_en=1 with the write rejected while flush=0, otherwise 0.
REQ-027 underflow SHALL be 1 in the cycle after rd_en=1 with empty=1 while flush=0, otherwise 0.
REQ-028 When FWFT=0, data_out SHALL load mem[rd_ptr] on an accepted read, giving 1-cycle latency, and otherwise hold its value; valid SHALL be 1 only in the cycle after an accepted read.
REQ-029 When FWFT=1, data_out SHALL equal mem[rd_ptr] combinationally and valid SHALL equal !empty; rd_en SHALL pop the displayed word, and the next word SHALL appear in the following cycle.
REQ-030 When FWFT=1, a word written into an empty FIFO SHALL become visible with valid=1 one cycle after the write edge.
REQ-031 flush=1 SHALL have priority over wr_en and rd_en: at the next edge wr_ptr, rd_ptr and count SHALL go to 0, wr_ack, overflow and underflow SHALL go to 0, FWFT=0 valid SHALL go to 0, memory SHALL not be cleared, and FWFT=0 data_out SHALL hold.
REQ-032 Memory SHALL have no reset and SHALL be written only on wr_acc.

Reset
REQ-033 rst_n=0 SHALL immediately, asynchronously, set wr_ptr, rd_ptr and count to 0, data_out to 0, and valid, wr_ack, overflow and underflow to 0, giving empty=1, full=0, almostempty=1 for ae_thresh>=0, and almostfull=(af_thresh==0).
REQ-034 Reset asserted mid-operation SHALL discard all contents, and the first write after release SHALL land at address 0.

Verification
REQ-035 The bench SHALL cover: DEPTH=16, FWFT=0, write 0x01..0x10 -> full=1 after the 16th edge; a 17th write -> overflow pulse, count holds 16; 16 reads -> data_out 0x01..0x10 in order, each with valid, 1 cycle after rd_en.
REQ-036 The bench SHALL cover: DEPTH=5 (non-power-of-2), 12 write/read pairs with count oscillating 0..3 -> pointers wrap 4->0 and data order is preserved.
REQ-037 The bench SHALL cover: full FIFO, wr_en=rd_en=1 with data_in=0xAA -> no overflow, count stays 16, wr_ack=1, and 0xAA is read last.
REQ-038 The bench SHALL cover: empty FIFO, wr_en=rd_en=1 -> underflow=1, wr_ack=1, count=1; and FWFT=1 -> data_out=written word with valid=1 on the next cycle.
REQ-039 The bench SHALL cover: af_thresh=12, ae_thresh=2 -> almostfull asserts at count 12, and almostempty deasserts at count 3.
REQ-040 The bench SHALL cover: count=7, flush with wr_en=1 -> count=0, empty=1, no wr_ack; and rst_n pulsed low mid-burst -> all outputs reach reset values without a clock edge.
